// File: rtl/datamemory_pkg.sv
// datamemory_pkg
// Shared definitions for the datamemory load/store unit:
//   - request size encodings (SZ_BYTE, SZ_HALF, SZ_WORD; 2'b11 is illegal)
//   - the LSU state enum (IDLE, RD, CAP, WR)
//   - ramWP levels (RAM_READ = 1, RAM_WRITE = 0)
//   - is_misaligned(): alignment / size legality test for a request
package datamemory_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic RAM_READ  = 1'b1;
   localparam logic RAM_WRITE = 1'b0;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      CAP  = 2'b10,
      WR   = 2'b11
   } lsu_state_t;

   // A request is rejected when its size code is illegal, or when the byte
   // offset does not sit on a boundary of the access size.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] lane);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lane[0];
         SZ_WORD: bad = (lane != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// lsu_lane_unit
// Purely combinational byte-lane logic for the load/store unit.
// Lanes are little-endian: byte k sits in word bits [8k+7:8k], and a
// half-word h = lane[1] sits in bits [16h+15:16h].
// Ports:
//   size        in   access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   lane        in   byte offset within the word (addr[1:0])
//   is_unsigned in   1 = zero-extend loads, 0 = sign-extend
//   word        in   word read from the RAM
//   wdata       in   right-aligned store data
//   load_data   out  selected lane, extended to 32 bits
//   merged      out  word with the store lane replaced by wdata
module lsu_lane_unit
   import datamemory_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        is_unsigned,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  byte_val;
   logic [15:0] half_val;

   // Load path: pick the addressed lane, then extend it.
   always_comb begin
      byte_val  = 8'(word >> {lane, 3'b000});
      half_val  = lane[1] ? word[31:16] : word[15:0];
      load_data = word;
      case (size)
         SZ_BYTE: load_data = is_unsigned ? {24'h000000, byte_val}
                                          : {{24{byte_val[7]}}, byte_val};
         SZ_HALF: load_data = is_unsigned ? {16'h0000, half_val}
                                          : {{16{half_val[15]}}, half_val};
         default: load_data = word;
      endcase
   end

   // Store path: overlay the low bits of wdata onto the addressed lane of
   // the word that was just read back, leaving the other lanes intact.
   always_comb begin
      merged = word;
      case (size)
         SZ_BYTE: merged[{lane, 3'b000} +: 8] = wdata[7:0];
         SZ_HALF: begin
            if (lane[1]) merged[31:16] = wdata[15:0];
            else         merged[15:0]  = wdata[15:0];
         end
         default: merged = wdata;
      endcase
   end

endmodule

// File: rtl/datamemory_lsu.sv
// datamemory_lsu
// Load/store initiator for the datamemory word RAM. Accepts byte-addressed
// LW/LH/LHU/LB/LBU/SW/SH/SB requests over valid/ready, turns them into word
// accesses (read-modify-write for sub-word stores) and returns extended
// load data with a one-cycle resp_valid pulse.
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_we, req_size        store flag and access size
//   req_unsigned            zero-extend loads when set
//   req_addr, req_wdata     byte address and right-aligned store data
//   resp_valid/rdata/err    completion pulse, load data, error flag
//   ramAdress/ramIn/ramWP   registered RAM word address, data, read/write
//   ramOut                  RAM read data, valid one edge after a read
module datamemory_lsu
   import datamemory_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] ramAdress,
   output logic [DATA_W-1:0] ramIn,
   output logic              ramWP,
   input  logic [DATA_W-1:0] ramOut
);

   lsu_state_t        state, state_n;
   logic              we_q, we_n;
   logic [1:0]        size_q, size_n;
   logic              uns_q, uns_n;
   logic [1:0]        lane_q, lane_n;
   logic [31:0]       wdata_q, wdata_n;
   logic [ADDR_W-1:0] adr_n;
   logic [DATA_W-1:0] ramin_n;
   logic              wp_n;
   logic              rvalid_n, rerr_n;
   logic [31:0]       rdata_n;
   logic [31:0]       load_data, merged;

   // Address bits above the RAM range are deliberately dropped (wrap).
   logic unused_addr_bits;
   assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

   assign req_ready = (state == IDLE);

   lsu_lane_unit u_lane (
      .size        (size_q),
      .lane        (lane_q),
      .is_unsigned (uns_q),
      .word        (ramOut),
      .wdata       (wdata_q),
      .load_data   (load_data),
      .merged      (merged)
   );

   // Reset forces ramWP to the read level immediately, so an operation
   // aborted before its WR edge can never land a write.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         we_q       <= 1'b0;
         size_q     <= SZ_BYTE;
         uns_q      <= 1'b0;
         lane_q     <= 2'b00;
         wdata_q    <= 32'h0;
         ramAdress  <= '0;
         ramIn      <= '0;
         ramWP      <= RAM_READ;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
      end else begin
         state      <= state_n;
         we_q       <= we_n;
         size_q     <= size_n;
         uns_q      <= uns_n;
         lane_q     <= lane_n;
         wdata_q    <= wdata_n;
         ramAdress  <= adr_n;
         ramIn      <= ramin_n;
         ramWP      <= wp_n;
         resp_valid <= rvalid_n;
         resp_rdata <= rdata_n;
         resp_err   <= rerr_n;
      end
   end

   // ramWP defaults to the read level so only the cycle spent in WR writes.
   // SW skips the read phase; SB/SH read the word first and merge in CAP.
   always_comb begin
      state_n  = state;
      we_n     = we_q;
      size_n   = size_q;
      uns_n    = uns_q;
      lane_n   = lane_q;
      wdata_n  = wdata_q;
      adr_n    = ramAdress;
      ramin_n  = ramIn;
      wp_n     = RAM_READ;
      rvalid_n = 1'b0;
      rdata_n  = resp_rdata;
      rerr_n   = resp_err;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (is_misaligned(req_size, req_addr[1:0])) begin
                  rvalid_n = 1'b1;
                  rerr_n   = 1'b1;
                  rdata_n  = 32'h0;
               end else begin
                  we_n    = req_we;
                  size_n  = req_size;
                  uns_n   = req_unsigned;
                  lane_n  = req_addr[1:0];
                  wdata_n = req_wdata;
                  adr_n   = req_addr[ADDR_W+1:2];
                  if (req_we && (req_size == SZ_WORD)) begin
                     ramin_n = req_wdata;
                     wp_n    = RAM_WRITE;
                     state_n = WR;
                  end else begin
                     state_n = RD;
                  end
               end
            end
         end
         RD: state_n = CAP;
         CAP: begin
            if (we_q) begin
               ramin_n = merged;
               wp_n    = RAM_WRITE;
               state_n = WR;
            end else begin
               rvalid_n = 1'b1;
               rerr_n   = 1'b0;
               rdata_n  = load_data;
               state_n  = IDLE;
            end
         end
         WR: begin
            rvalid_n = 1'b1;
            rerr_n   = 1'b0;
            rdata_n  = 32'h0;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_datamemory_lsu.sv
// tb_datamemory_lsu
// Directed bench for datamemory_lsu with a behavioural word RAM attached to
// the ramAdress/ramIn/ramWP/ramOut port. Expected values are hand-computed.
module tb_datamemory_lsu;
   import datamemory_pkg::*;

   localparam int ADDR_W = 10;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_we = 1'b0;
   logic [1:0]        req_size = 2'b00;
   logic              req_unsigned = 1'b0;
   logic [31:0]       req_addr = 32'h0;
   logic [31:0]       req_wdata = 32'h0;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] ramAdress;
   logic [31:0]       ramIn;
   logic              ramWP;
   logic [31:0]       ramOut = 32'h0;

   int checks = 0;
   int passes = 0;

   logic [31:0]       mem [0:(1<<ADDR_W)-1];
   int                wr_count = 0;
   logic              preload_en = 1'b0;
   logic [ADDR_W-1:0] preload_addr = '0;
   logic [31:0]       preload_data = 32'h0;
   logic [ADDR_W-1:0] last_wr_adr = '0;
   logic [31:0]       last_wr_data = 32'h0;

   always #5 clock = ~clock;

   datamemory_lsu #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .ramAdress    (ramAdress),
      .ramIn        (ramIn),
      .ramWP        (ramWP),
      .ramOut       (ramOut)
   );

   // Word RAM: writes on every edge that samples ramWP=0, otherwise registers
   // the addressed word onto ramOut. The preload port lets the bench seed
   // words while the unit is idle.
   always @(posedge clock) begin
      if (preload_en) begin
         mem[preload_addr] <= preload_data;
      end else if (ramWP == RAM_WRITE) begin
         mem[ramAdress] <= ramIn;
         wr_count       <= wr_count + 1;
      end
      if (ramWP == RAM_READ) ramOut <= mem[ramAdress];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed === expected) passes++;
      else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
   endtask

   task automatic preload(input logic [ADDR_W-1:0] adr, input logic [31:0] data);
      @(negedge clock);
      preload_addr = adr;
      preload_data = data;
      preload_en   = 1'b1;
      @(negedge clock);
      preload_en   = 1'b0;
   endtask

   // Issue one request, wait (bounded) for its response and check latency,
   // data, error flag, pulse width and the number of RAM write edges.
   task automatic applyStimulus(input string tag, input logic we,
                                input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int exp_lat, input logic [31:0] exp_rdata,
                                input logic exp_err, input int exp_writes);
      int lat;
      int w0;
      logic [ADDR_W-1:0] adr0;
      @(negedge clock);
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      req_valid    = 1'b1;
      w0           = wr_count;
      adr0         = ramAdress;
      checkOutput({tag, " ready"}, 32'(req_ready), 32'd1);
      @(posedge clock);
      #1 req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
         if (ramWP == RAM_WRITE) begin
            last_wr_adr  = ramAdress;
            last_wr_data = ramIn;
         end
      end while (!resp_valid && lat < 8);
      checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
      checkOutput({tag, " rdata"}, resp_rdata, exp_rdata);
      checkOutput({tag, " err"}, 32'(resp_err), 32'(exp_err));
      if (exp_err) begin
         checkOutput({tag, " adr held"}, 32'(ramAdress), 32'(adr0));
         checkOutput({tag, " wp held"}, 32'(ramWP), 32'd1);
         checkOutput({tag, " ready kept"}, 32'(req_ready), 32'd1);
      end
      @(negedge clock);
      checkOutput({tag, " pulse"}, 32'(resp_valid), 32'd0);
      checkOutput({tag, " writes"}, 32'(wr_count - w0), 32'(exp_writes));
   endtask

   initial begin
      int w0;
      int seen;
      repeat (2) @(negedge clock);
      checkOutput("rst ramWP", 32'(ramWP), 32'd1);
      checkOutput("rst ramAdress", 32'(ramAdress), 32'd0);
      checkOutput("rst ramIn", ramIn, 32'd0);
      checkOutput("rst resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst resp_rdata", resp_rdata, 32'd0);
      checkOutput("rst resp_err", 32'(resp_err), 32'd0);
      checkOutput("rst ready", 32'(req_ready), 32'd1);
      reset_n = 1'b1;

      // Word load
      preload(10'd1, 32'h000007D0);
      applyStimulus("LW 0x4", 1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 3, 32'h000007D0, 1'b0, 0);

      // Word store and read-back
      applyStimulus("SW 0x8", 1'b1, SZ_WORD, 1'b0, 32'h8, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1);
      checkOutput("SW wr adr", 32'(last_wr_adr), 32'd2);
      checkOutput("SW wr data", last_wr_data, 32'hDEADBEEF);
      applyStimulus("LW 0x8", 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 3, 32'hDEADBEEF, 1'b0, 0);

      // Byte store read-modify-write, then signed and unsigned byte loads
      preload(10'd2, 32'h11223344);
      applyStimulus("SB 0xB", 1'b1, SZ_BYTE, 1'b0, 32'hB, 32'h000000A5, 4, 32'h0, 1'b0, 1);
      checkOutput("SB word2", mem[2], 32'hA5223344);
      applyStimulus("LB 0xB", 1'b0, SZ_BYTE, 1'b0, 32'hB, 32'h0, 3, 32'hFFFFFFA5, 1'b0, 0);
      applyStimulus("LBU 0xB", 1'b0, SZ_BYTE, 1'b1, 32'hB, 32'h0, 3, 32'h000000A5, 1'b0, 0);
      applyStimulus("LBU 0x9", 1'b0, SZ_BYTE, 1'b1, 32'h9, 32'h0, 3, 32'h00000033, 1'b0, 0);

      // Half-word loads and a half-word store in the upper lane
      preload(10'd1, 32'h80001234);
      applyStimulus("LH 0x6", 1'b0, SZ_HALF, 1'b0, 32'h6, 32'h0, 3, 32'hFFFF8000, 1'b0, 0);
      applyStimulus("LHU 0x6", 1'b0, SZ_HALF, 1'b1, 32'h6, 32'h0, 3, 32'h00008000, 1'b0, 0);
      applyStimulus("LH 0x4", 1'b0, SZ_HALF, 1'b0, 32'h4, 32'h0, 3, 32'h00001234, 1'b0, 0);
      applyStimulus("SH 0x6", 1'b1, SZ_HALF, 1'b0, 32'h6, 32'h5555BEEF, 4, 32'h0, 1'b0, 1);
      checkOutput("SH word1", mem[1], 32'hBEEF1234);
      applyStimulus("LW wrap", 1'b0, SZ_WORD, 1'b0, 32'h1004, 32'h0, 3, 32'hBEEF1234, 1'b0, 0);

      // Misaligned and illegal-size requests
      applyStimulus("LW 0x2", 1'b0, SZ_WORD, 1'b0, 32'h2, 32'h0, 1, 32'h0, 1'b1, 0);
      applyStimulus("SH 0x5", 1'b1, SZ_HALF, 1'b0, 32'h5, 32'hFFFF, 1, 32'h0, 1'b1, 0);
      applyStimulus("size 11", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0);

      // Reset while an SH sits in CAP: no write, no response
      preload(10'd2, 32'hCAFEF00D);
      @(negedge clock);
      req_we = 1'b1; req_size = SZ_HALF; req_unsigned = 1'b0;
      req_addr = 32'h8; req_wdata = 32'h00001111; req_valid = 1'b1;
      w0 = wr_count;
      @(posedge clock);
      #1 req_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b0;
      #1 checkOutput("abort ramWP", 32'(ramWP), 32'd1);
      seen = 0;
      repeat (3) begin
         @(negedge clock);
         if (resp_valid) seen++;
      end
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clock);
         if (resp_valid) seen++;
      end
      checkOutput("abort no resp", 32'(seen), 32'd0);
      checkOutput("abort writes", 32'(wr_count - w0), 32'd0);
      checkOutput("abort word2", mem[2], 32'hCAFEF00D);
      checkOutput("abort ready", 32'(req_ready), 32'd1);
      applyStimulus("LW after", 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 3, 32'hCAFEF00D, 1'b0, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
